// File: rtl/fc_buf_pkg.sv
// Shared types and constants for the FC-layer ping-pong activation buffer.
// FC_PINGPONG_OUT_REG_EN selects a read latency of 2 (extra output register) instead of 1.
package fc_buf_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  function automatic int bank_bits(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  localparam int BANKS_DEF = 4;
  localparam int BW = bank_bits(BANKS_DEF);

`ifdef FC_PINGPONG_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/fc_buf_bank.sv
// One bank of the ping-pong buffer: simple dual-port RAM holding both halves,
// synchronous write port and registered read port. Contents are not reset.
module fc_buf_bank #(
  parameter int DW     = 16,
  parameter int WORDS  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem_r [WORDS];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/fc_pingpong_buf.sv
// Double-buffered multi-bank activation buffer: rows are written into the fill half
// while the reader serialises the other half (row-major, bank-minor). Macro: FC_PINGPONG_OUT_REG_EN.
module fc_pingpong_buf
  import fc_buf_pkg::*;
#(
  parameter int DW    = 16,
  parameter int BANKS = 4,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DW*BANKS-1:0]         wr_data,
  input  logic                        wr_last,
  input  logic                        rd_start,
  output logic                        rd_busy,
  output logic                        out_valid,
  output logic [DW-1:0]               out_data,
  output logic [bank_bits(BANKS)-1:0] out_bank,
  output logic [AW-1:0]               out_row,
  output logic                        out_last,
  output logic [1:0]                  full_cnt
);

  localparam int NBW = bank_bits(BANKS);
  localparam int RAW = AW + 1;
  localparam logic [RAW-1:0] DEPTH_C   = RAW'(DEPTH);
  localparam logic [NBW-1:0] LAST_BANK = NBW'(BANKS - 1);
  localparam logic [1:0]     DRAIN_END = 2'(RD_LAT - 1);

  logic            wr_sel_r, rd_sel_r;
  logic [RAW-1:0]  wr_row_r;
  logic [RAW-1:0]  tile_len_r [2];
  logic [1:0]      full_cnt_r;
  rd_state_e       state_r, state_nxt_s;
  logic [RAW-1:0]  rd_row_r;
  logic [NBW-1:0]  rd_bank_r;
  logic [1:0]      drain_cnt_r;
  logic            iss_valid_r, iss_last_r;
  logic [NBW-1:0]  iss_bank_r;
  logic [AW-1:0]   iss_row_r;

  logic            wr_acc_s, wr_store_s, wr_close_s;
  logic            issue_s, free_s, last_iss_s;
  logic [RAW-1:0]  cur_len_s, waddr_s, raddr_s;
  logic [DW-1:0]   rdata_s [BANKS];
  logic [DW-1:0]   s1_data_s;

  // A row beyond DEPTH is only admitted when it closes the tile; it is not stored.
  assign wr_ready   = (full_cnt_r != 2'd2) && ((wr_row_r < DEPTH_C) || wr_last);
  assign wr_acc_s   = wr_valid & wr_ready;
  assign wr_store_s = wr_acc_s & (wr_row_r < DEPTH_C);
  assign wr_close_s = wr_acc_s & wr_last;
  assign waddr_s    = wr_sel_r ? (DEPTH_C + wr_row_r) : wr_row_r;
  assign raddr_s    = rd_sel_r ? (DEPTH_C + rd_row_r) : rd_row_r;
  assign cur_len_s  = tile_len_r[rd_sel_r];
  assign last_iss_s = (rd_row_r == (cur_len_s - RAW'(1))) && (rd_bank_r == LAST_BANK);
  assign rd_busy    = (state_r != RD_IDLE);
  assign full_cnt   = full_cnt_r;

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    fc_buf_bank #(.DW(DW), .WORDS(2 * DEPTH), .ADDR_W(RAW)) u_bank (
      .clk   (clk),
      .we    (wr_store_s),
      .waddr (waddr_s),
      .wdata (wr_data[g*DW +: DW]),
      .re    (issue_s),
      .raddr (raddr_s),
      .rdata (rdata_s[g])
    );
  end

  // Writer bookkeeping: fill row, fill half select, tile lengths
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_r      <= 1'b0;
      wr_row_r      <= '0;
      tile_len_r[0] <= '0;
      tile_len_r[1] <= '0;
    end else if (wr_close_s) begin
      tile_len_r[wr_sel_r] <= wr_store_s ? (wr_row_r + RAW'(1)) : DEPTH_C;
      wr_sel_r             <= ~wr_sel_r;
      wr_row_r             <= '0;
    end else if (wr_store_s) begin
      wr_row_r <= wr_row_r + RAW'(1);
    end
  end

  // Occupancy: a close and a free in the same cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cnt_r <= 2'd0;
    end else begin
      case ({wr_close_s, free_s})
        2'b10:   full_cnt_r <= full_cnt_r + 2'd1;
        2'b01:   full_cnt_r <= full_cnt_r - 2'd1;
        default: full_cnt_r <= full_cnt_r;
      endcase
    end
  end

  // Reader state register and issue counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RD_IDLE;
      rd_sel_r    <= 1'b0;
      rd_row_r    <= '0;
      rd_bank_r   <= '0;
      drain_cnt_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= (state_r == RD_DRAIN) ? (drain_cnt_r + 2'd1) : 2'd0;
      if (free_s) begin
        rd_sel_r <= ~rd_sel_r;
      end
      if (state_r == RD_IDLE) begin
        rd_row_r  <= '0;
        rd_bank_r <= '0;
      end else if (issue_s && (rd_bank_r == LAST_BANK)) begin
        rd_bank_r <= '0;
        rd_row_r  <= rd_row_r + RAW'(1);
      end else if (issue_s) begin
        rd_bank_r <= rd_bank_r + NBW'(1);
      end
    end
  end

  // Reader next-state and control
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    free_s      = 1'b0;
    case (state_r)
      RD_IDLE: begin
        if (rd_start && (full_cnt_r != 2'd0)) begin
          state_nxt_s = RD_RUN;
        end else begin
          state_nxt_s = RD_IDLE;
        end
      end
      RD_RUN: begin
        issue_s = 1'b1;
        if (last_iss_s) begin
          state_nxt_s = RD_DRAIN;
        end else begin
          state_nxt_s = RD_RUN;
        end
      end
      RD_DRAIN: begin
        if (drain_cnt_r == DRAIN_END) begin
          free_s      = 1'b1;
          state_nxt_s = RD_IDLE;
        end else begin
          state_nxt_s = RD_DRAIN;
        end
      end
      default: state_nxt_s = RD_IDLE;
    endcase
  end

  // Sideband travelling alongside the RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_r <= 1'b0;
      iss_bank_r  <= '0;
      iss_row_r   <= '0;
      iss_last_r  <= 1'b0;
    end else begin
      iss_valid_r <= issue_s;
      iss_bank_r  <= rd_bank_r;
      iss_row_r   <= rd_row_r[AW-1:0];
      iss_last_r  <= issue_s & last_iss_s;
    end
  end

  // RAM read registers are not reset, so gate the data with its valid
  assign s1_data_s = iss_valid_r ? rdata_s[iss_bank_r] : '0;

`ifdef FC_PINGPONG_OUT_REG_EN
  // Output register stage: all out_* move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bank  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= iss_valid_r;
      out_data  <= s1_data_s;
      out_bank  <= iss_bank_r;
      out_row   <= iss_row_r;
      out_last  <= iss_last_r;
    end
  end
`else
  assign out_valid = iss_valid_r;
  assign out_data  = s1_data_s;
  assign out_bank  = iss_bank_r;
  assign out_row   = iss_row_r;
  assign out_last  = iss_last_r;
`endif

endmodule

// File: tb/tb_fc_pingpong_buf.sv
// Scoreboard bench for fc_pingpong_buf (DEPTH=4): writer/reader stimulus feeds a
// tile-level reference model; a negedge monitor compares every presented word.
module tb_fc_pingpong_buf;
  import fc_buf_pkg::*;

  localparam int DW = 16, BANKS = 4, DEPTH = 4, AW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_valid = 1'b0, wr_last = 1'b0, rd_start = 1'b0;
  logic [DW*BANKS-1:0] wr_data = '0;
  logic wr_ready, rd_busy, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [1:0] out_bank;
  logic [AW-1:0] out_row;
  logic [1:0] full_cnt;

  fc_pingpong_buf #(.DW(DW), .BANKS(BANKS), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_last(wr_last), .rd_start(rd_start), .rd_busy(rd_busy), .out_valid(out_valid),
    .out_data(out_data), .out_bank(out_bank), .out_row(out_row), .out_last(out_last),
    .full_cnt(full_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] data; int bank; int row; bit last;} word_t;
  word_t exp_q[$];
  word_t pend_q[$];
  logic [DW*BANKS-1:0] cur_rows[$];
  int model_full = 0;
  int total = 0, bad = 0;
  bit in_tile = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Model: rows past DEPTH are dropped; a closed tile becomes a word list.
  task automatic model_accept(input logic [DW*BANKS-1:0] d, input bit last);
    word_t w;
    if (cur_rows.size() < DEPTH) cur_rows.push_back(d);
    if (last) begin
      for (int r = 0; r < cur_rows.size(); r++)
        for (int b = 0; b < BANKS; b++) begin
          w.data = cur_rows[r][b*DW +: DW];
          w.bank = b;
          w.row  = r;
          w.last = (r == cur_rows.size() - 1) && (b == BANKS - 1);
          pend_q.push_back(w);
        end
      cur_rows.delete();
      model_full++;
    end
  endtask

  task automatic write_row(input logic [DW*BANKS-1:0] d, input bit last, output int waits);
    bit ok = 0;
    waits = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    while (!ok && waits < 100) begin
      #1;
      if (wr_ready) ok = 1;
      else waits++;
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    if (ok) model_accept(d, last);
    else flag("wr_accept_timeout");
  endtask

  task automatic write_tile(input int len, input bit overflow);
    int w;
    for (int r = 0; r < len; r++)
      write_row({$urandom, $urandom}, (r == len - 1) && !overflow, w);
    if (overflow) write_row({$urandom, $urandom}, 1'b1, w);
  endtask

  task automatic start_read();
    word_t w;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    do begin
      if (pend_q.size() == 0) break;
      w = pend_q.pop_front();
      exp_q.push_back(w);
    end while (!w.last);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rd_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reader_idle", rd_busy, 0);
    model_full--;
  endtask

  // Monitor: every presented word must match the next expected one, with no gaps in a tile
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      in_tile = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        flag("unexpected_out_valid");
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_bank", out_bank, e.bank);
        chk("out_row", out_row, e.row);
        chk("out_last", out_last, e.last);
      end
      in_tile = !out_last;
    end else if (in_tile) begin
      flag("gap_in_tile");
      in_tile = 0;
    end
  end

  initial begin
    int w, k;
    logic [DW*BANKS-1:0] d;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_bank", out_bank, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_full_cnt", full_cnt, 0);

    // Basic tile: lanes = row*16 + bank
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < BANKS; b++) d[b*DW +: DW] = 16'(r * 16 + b);
      write_row(d, r == 2, w);
    end
    chk("basic_full_cnt", full_cnt, 1);
    start_read();
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_word_latency", k, RD_LAT);
    wait_idle();
    chk("basic_full_after", full_cnt, 0);

    // rd_start with nothing to read is ignored
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    chk("empty_start_busy", rd_busy, 0);
    @(negedge clk);
    chk("empty_start_busy2", rd_busy, 0);

    // Ping-pong overlap: write B while A drains
    write_tile(2, 0);
    start_read();
    for (int r = 0; r < 2; r++) begin
      write_row({$urandom, $urandom}, r == 1, w);
      chk("overlap_no_stall", w, 0);
    end
    wait_idle();
    chk("overlap_full_cnt", full_cnt, 1);
    start_read();
    wait_idle();

    // Backpressure: two tiles with no reader
    write_tile(2, 0);
    write_tile(3, 0);
    chk("bp_full_cnt", full_cnt, 2);
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_wr_ready", wr_ready, 0);
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("bp_full_hold", full_cnt, 2);
    start_read();
    k = 0;
    while (full_cnt != 2'd1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_full_drop", full_cnt, 1);
    chk("bp_ready_back", wr_ready, 1);
    model_full--;
    start_read();
    wait_idle();

    // Overflow: DEPTH rows without last, then a closing beat
    for (int r = 0; r < DEPTH; r++) write_row({$urandom, $urandom}, 1'b0, w);
    wr_valid = 1'b1; wr_last = 1'b0;
    #1;
    chk("ovf_wr_ready", wr_ready, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    write_row({$urandom, $urandom}, 1'b1, w);
    chk("ovf_full_cnt", full_cnt, 1);
    chk("ovf_words", pend_q.size(), DEPTH * BANKS);
    start_read();
    wait_idle();

    // Tile close in the same cycle as the reader frees its half
    write_tile(2, 0);
    start_read();
    write_row({$urandom, $urandom}, 1'b0, w);
    k = 0;
    while (!out_last && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("sim_saw_last", out_last, 1);
    wr_valid = 1'b1; wr_last = 1'b1; d = {$urandom, $urandom}; wr_data = d;
    #1;
    chk("sim_wr_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
    model_accept(d, 1'b1);
    chk("sim_full_cnt", full_cnt, 1);
    chk("sim_rd_busy", rd_busy, 0);
    wait_idle();
    start_read();
    wait_idle();

    // Randomised tiles with random reads
    for (int t = 0; t < 8; t++) begin
      if (model_full == 2) begin
        start_read();
        wait_idle();
      end
      write_tile($urandom_range(DEPTH, 1), ($urandom % 4) == 0);
      repeat ($urandom % 2) @(negedge clk);
      if ($urandom % 2) begin
        start_read();
        wait_idle();
      end
    end
    while (model_full > 0) begin
      start_read();
      wait_idle();
    end

    // Reset mid-RUN
    write_tile(3, 0);
    start_read();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); pend_q.delete(); cur_rows.delete();
    model_full = 0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_full_cnt", full_cnt, 0);
    chk("rst_mid_wr_ready", wr_ready, 1);
    chk("rst_mid_rd_busy", rd_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    write_tile(2, 0);
    start_read();
    wait_idle();

    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("pend_q_empty", pend_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
